eight_bit_sar_search: RTL and testbench

Successive-approximation search controller that drives the probe operand `b` of an external 8-bit magnitude comparator and reads back its `agb`/`aeb`/`alb` flags to recover an unknown 8-bit operand `a`. It is the initiator side of the comparator interface: the comparator answers, this block asks. One search resolves `a` MSB-first in at most 9 cycles and reports the result, plus an error if the comparator answers inconsistently.

---
 rtl/eight_bit_sar_search.sv | 102 ++++++++++
 tb/tb_eight_bit_sar_search.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/eight_bit_sar_search.sv
// eight_bit_sar_search: MSB-first successive-approximation controller
// that recovers an 8-bit operand through an external magnitude comparator.
module eight_bit_sar_search (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       agb,
  input  logic       aeb,
  input  logic       alb,
  output logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
    VERIFY = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] acc;
  logic [2:0] idx;

  logic       onehot;
  logic [7:0] base;
  logic [7:0] trial;
  logic [2:0] idx_m1;

  assign onehot = (agb & ~aeb & ~alb)
                | (~agb & aeb & ~alb)
                | (~agb & ~aeb & alb);
  assign base   = agb ? b : acc;
  assign idx_m1 = idx - 3'd1;
  assign trial  = base | (8'h01 << idx_m1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= 8'h00;
      idx    <= 3'd0;
      b      <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 8'h00;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            b      <= 8'h80;
            acc    <= 8'h00;
            idx    <= 3'd7;
            busy   <= 1'b1;
            err    <= 1'b0;
            result <= 8'h00;
            state  <= TEST;
          end
        end
        TEST: begin
          if (!onehot) begin
            err    <= 1'b1;
            result <= b;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end else if (aeb) begin
            result <= b;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            acc <= base;
            if (idx != 3'd0) begin
              b   <= trial;
              idx <= idx_m1;
            end else begin
              // all bits decided without a hit; one last probe confirms
              b     <= base;
              state <= VERIFY;
            end
          end
        end
        VERIFY: begin
          result <= b;
          if (!(aeb && !agb && !alb)) err <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_sar_search.sv
// tb_eight_bit_sar_search: directed scoreboard bench with a modelled
// comparator and injectable flag faults.
module tb_eight_bit_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       agb;
  logic       aeb;
  logic       alb;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       err;

  logic [7:0] a;
  int         fault;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] res;
    logic       er;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] bq[$];

  eight_bit_sar_search dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .agb    (agb),
    .aeb    (aeb),
    .alb    (alb),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparator model; fault 1 = no flag, 2 = agb+alb, 3 = alb only
  always_comb begin
    agb = (a > b);
    aeb = (a == b);
    alb = (a < b);
    if (fault == 1) begin
      agb = 1'b0; aeb = 1'b0; alb = 1'b0;
    end else if (fault == 2) begin
      agb = 1'b1; aeb = 1'b0; alb = 1'b1;
    end else if (fault == 3) begin
      agb = 1'b0; aeb = 1'b0; alb = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [7:0] av, input int fprobe,
                     input int fkind, input int spur_k,
                     input logic [7:0] eres, input logic eerr,
                     input int elat);
    exp_t e;
    exp_t x;
    bit   seen;
    e.res = eres; e.er = eerr; e.lat = elat;
    sb.push_back(e);
    a = av;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_e0", {31'd0, busy}, 32'd1);
    if (bq.size() > 0) chk("b_probe", {24'd0, b}, {24'd0, bq.pop_front()});
    else chk("b_e0", {24'd0, b}, 32'h80);
    for (int k = 1; k <= 12; k++) begin
      if (k == fprobe) fault = fkind;
      if (k == spur_k) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fault = 0;
      start = 1'b0;
      if (done) begin
        seen = 1;
        x = sb.pop_front();
        chk("result", {24'd0, result}, {24'd0, x.res});
        chk("err", {31'd0, err}, {31'd0, x.er});
        chk("latency", k, x.lat);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("result_hold", {24'd0, result}, {24'd0, x.res});
        break;
      end else if (bq.size() > 0) begin
        chk("b_probe", {24'd0, b}, {24'd0, bq.pop_front()});
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $error("FAIL timeout got=no_done exp=done");
      void'(sb.pop_front());
    end
    bq.delete();
  endtask

  initial begin
    bit stray;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    fault = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_b", {24'd0, b}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // abort a search with reset sampled at E3
    a = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_b", {24'd0, b}, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {24'd0, result}, 32'h0);
    chk("abort_err", {31'd0, err}, 32'd0);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) stray = 1;
    end
    chk("abort_no_done", {31'd0, stray}, 32'd0);

    run(8'h80, 0, 0, 0, 8'h80, 1'b0, 1);

    bq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    run(8'h00, 0, 0, 0, 8'h00, 1'b0, 9);

    bq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    run(8'hFF, 0, 0, 0, 8'hFF, 1'b0, 8);

    run(8'h5A, 0, 0, 3, 8'h5A, 1'b0, 7);

    run(8'h5A, 1, 1, 0, 8'h80, 1'b1, 1);

    run(8'h5A, 3, 2, 0, 8'h60, 1'b1, 3);

    run(8'h00, 9, 3, 0, 8'h00, 1'b1, 9);

    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
